// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: instruction type codes and default widths.
// Imported by the ROB, decoder, reservation stations and load/store buffer.
package rob_pkg;

  localparam int ROB_WIDTH_DEF = 4;
  localparam int REG_WIDTH_DEF = 5;

  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;
  localparam logic [1:0] TYPE_NOP    = 2'd3;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: issue at tail, CDB write-back, retire at head.
// Ports: clk_in/rst_in/rdy_in; issue_* + free/free_tag (decoder side);
//   wb_* (CDB); commit_* (regfile/LSB); clear/redirect_pc (mispredict flush).
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int REG_WIDTH = REG_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic [31:0]          issue_pred_pc,
  output logic                 free,
  output logic [ROB_WIDTH-1:0] free_tag,
  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_tag,
  output logic [1:0]           commit_type,
  output logic [REG_WIDTH-1:0] commit_rd,
  output logic [31:0]          commit_value,
  output logic                 clear,
  output logic [31:0]          redirect_pc
);

  localparam int DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL = (ROB_WIDTH + 1)'(DEPTH);

  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     ready_q, ready_d;

  logic [1:0]           type_q  [DEPTH];
  logic [REG_WIDTH-1:0] rd_q    [DEPTH];
  logic [31:0]          value_q [DEPTH];
  logic [31:0]          pred_q  [DEPTH];

  logic                 cvalid_q;
  logic [ROB_WIDTH-1:0] ctag_q;
  logic [1:0]           ctype_q;
  logic [REG_WIDTH-1:0] crd_q;
  logic [31:0]          cvalue_q;
  logic                 clear_q;
  logic [31:0]          redir_q;

  logic issue_acc;
  logic wb_acc;
  logic commit_fire;
  logic mispredict;

  // free depends on registers only so the decoder sees no comb loop
  assign free     = (count_q != FULL) && !clear_q;
  assign free_tag = tail_q;

  assign issue_acc   = rdy_in && issue_valid && free;
  assign wb_acc      = rdy_in && wb_valid && !clear_q
                       && busy_q[wb_tag];
  assign commit_fire = rdy_in && !clear_q
                       && busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire
                       && (type_q[head_q] == TYPE_BRANCH)
                       && (value_q[head_q] != pred_q[head_q]);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;

    if (wb_acc) ready_d[wb_tag] = 1'b1;

    if (issue_acc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end

    if (commit_fire) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    unique case ({issue_acc, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // flush overrides any same-cycle issue or write-back
    if (mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // payload needs no reset: busy/ready gate every use
  always_ff @(posedge clk_in) begin
    if (issue_acc) begin
      type_q[tail_q] <= issue_type;
      rd_q[tail_q]   <= issue_rd;
      pred_q[tail_q] <= issue_pred_pc;
    end
    if (wb_acc) value_q[wb_tag] <= wb_value;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      ctype_q  <= '0;
      crd_q    <= '0;
      cvalue_q <= '0;
      clear_q  <= 1'b0;
      redir_q  <= '0;
    end else if (rdy_in) begin
      cvalid_q <= commit_fire;
      clear_q  <= mispredict;
      if (commit_fire) begin
        ctag_q   <= head_q;
        ctype_q  <= type_q[head_q];
        crd_q    <= rd_q[head_q];
        cvalue_q <= value_q[head_q];
      end
      if (mispredict) redir_q <= value_q[head_q];
    end
  end

  // pulses are held while frozen and shown once rdy_in returns
  assign commit_valid = cvalid_q && rdy_in;
  assign clear        = clear_q && rdy_in;
  assign commit_tag   = ctag_q;
  assign commit_type  = ctype_q;
  assign commit_rd    = crd_q;
  assign commit_value = cvalue_q;
  assign redirect_pc  = redir_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int RW = 4;
  localparam int GW = 5;
  localparam int DEPTH = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_type = '0;
  logic [GW-1:0] issue_rd = '0;
  logic [31:0]   issue_pred_pc = '0;
  logic          free;
  logic [RW-1:0] free_tag;
  logic          wb_valid = 1'b0;
  logic [RW-1:0] wb_tag = '0;
  logic [31:0]   wb_value = '0;
  logic          commit_valid;
  logic [RW-1:0] commit_tag;
  logic [1:0]    commit_type;
  logic [GW-1:0] commit_rd;
  logic [31:0]   commit_value;
  logic          clear;
  logic [31:0]   redirect_pc;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pred_pc(issue_pred_pc),
    .free(free), .free_tag(free_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_type(commit_type), .commit_rd(commit_rd),
    .commit_value(commit_value), .clear(clear),
    .redirect_pc(redirect_pc)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: a queue of in-flight instructions, oldest first
  typedef struct {
    logic [RW-1:0] tag;
    logic [1:0]    typ;
    logic [GW-1:0] rd;
    logic [31:0]   val;
    logic [31:0]   pred;
    bit            rdy;
  } ment_t;

  ment_t         mq[$];
  logic [RW-1:0] m_tail;
  bit            m_cv, m_clear;
  logic [RW-1:0] m_ctag;
  logic [1:0]    m_ctype;
  logic [GW-1:0] m_crd;
  logic [31:0]   m_cval, m_redir;
  bit            s_fire, s_acc, s_mis;
  ment_t         s_h;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mq.delete();
      m_tail = 0; m_cv = 0; m_clear = 0;
      m_ctag = 0; m_ctype = 0; m_crd = 0; m_cval = 0; m_redir = 0;
    end else if (rdy_in) begin
      s_fire = !m_clear && mq.size() > 0 && mq[0].rdy;
      if (s_fire) s_h = mq[0];
      s_acc = issue_valid && mq.size() < DEPTH && !m_clear;
      if (wb_valid && !m_clear)
        foreach (mq[i])
          if (mq[i].tag == wb_tag) begin
            mq[i].val = wb_value;
            mq[i].rdy = 1;
          end
      m_cv = s_fire;
      s_mis = 0;
      if (s_fire) begin
        m_ctag = s_h.tag; m_ctype = s_h.typ;
        m_crd = s_h.rd;   m_cval = s_h.val;
        void'(mq.pop_front());
        s_mis = (s_h.typ == TYPE_BRANCH) && (s_h.val != s_h.pred);
      end
      m_clear = s_mis;
      if (s_mis) begin
        mq.delete();
        m_tail = 0;
        m_redir = s_h.val;
      end else if (s_acc) begin
        mq.push_back('{tag: m_tail, typ: issue_type, rd: issue_rd,
                       val: 32'h0, pred: issue_pred_pc, rdy: 0});
        m_tail = m_tail + 1'b1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("free", free, (mq.size() != DEPTH) && !m_clear);
      chk("free_tag", free_tag, m_tail);
      chk("commit_valid", commit_valid, m_cv && rdy_in);
      chk("commit_tag", commit_tag, m_ctag);
      chk("commit_type", commit_type, m_ctype);
      chk("commit_rd", commit_rd, m_crd);
      chk("commit_value", commit_value, m_cval);
      chk("clear", clear, m_clear && rdy_in);
      chk("redirect_pc", redirect_pc, m_redir);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle();
    issue_valid = 0;
    wb_valid = 0;
    rdy_in = 1;
  endtask

  task automatic iss(input logic [1:0] t, input logic [GW-1:0] rd,
                     input logic [31:0] p);
    issue_valid = 1;
    issue_type = t;
    issue_rd = rd;
    issue_pred_pc = p;
  endtask

  task automatic wb(input logic [RW-1:0] t, input logic [31:0] v);
    wb_valid = 1;
    wb_tag = t;
    wb_value = v;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1;
    #1;
    rst_in = 0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst free", free, 1);
    chk("rst free_tag", free_tag, 0);
    chk("rst commit_valid", commit_valid, 0);
    chk("rst clear", clear, 0);
    chk("rst redirect", redirect_pc, 0);
    rst_in = 0;
    tick();

    // single REG instruction, minimum latency
    iss(TYPE_REG, 3, 0);
    tick();
    chk("A free_tag", free_tag, 1);
    issue_valid = 0;
    wb(0, 32'h55);
    tick();
    chk("A early commit", commit_valid, 0);
    wb_valid = 0;
    tick();
    chk("A commit_valid", commit_valid, 1);
    chk("A commit_tag", commit_tag, 0);
    chk("A commit_rd", commit_rd, 3);
    chk("A commit_value", commit_value, 32'h55);
    chk("A commit_type", commit_type, TYPE_REG);
    tick();
    chk("A pulse ends", commit_valid, 0);

    // fill to 16, hold the 17th, retire tag 0, tail wraps
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      iss(TYPE_REG, GW'(i), 0);
      tick();
    end
    iss(TYPE_REG, 17, 0);
    chk("B full free", free, 0);
    chk("B full tag", free_tag, 0);
    tick();
    chk("B held free", free, 0);
    chk("B held tag", free_tag, 0);
    wb(0, 32'h1000);
    tick();
    chk("B wb no commit", commit_valid, 0);
    chk("B wb still full", free, 0);
    wb_valid = 0;
    tick();
    chk("B commit_valid", commit_valid, 1);
    chk("B commit_tag", commit_tag, 0);
    chk("B free after", free, 1);
    chk("B wrap tag", free_tag, 0);
    tick();
    chk("B 17th accepted", free_tag, 1);
    chk("B full again", free, 0);
    idle();

    // asynchronous reset with five live entries and a pulse up
    do_reset();
    for (int i = 0; i < 6; i++) begin
      iss(TYPE_REG, GW'(i), 0);
      tick();
    end
    idle();
    wb(0, 32'h11);
    tick();
    wb_valid = 0;
    tick();
    chk("C pre-reset commit", commit_valid, 1);
    rst_in = 1;
    #1;
    chk("C rst free", free, 1);
    chk("C rst free_tag", free_tag, 0);
    chk("C rst commit_valid", commit_valid, 0);
    chk("C rst clear", clear, 0);
    rst_in = 0;
    tick();

    // out-of-order write-back, in-order retirement
    do_reset();
    iss(TYPE_REG, 1, 0); tick();
    iss(TYPE_REG, 2, 0); tick();
    iss(TYPE_REG, 3, 0); tick();
    issue_valid = 0;
    wb(2, 32'hA2); tick();
    chk("D no commit yet", commit_valid, 0);
    wb(0, 32'hA0); tick();
    wb(1, 32'hA1); tick();
    chk("D c0 valid", commit_valid, 1);
    chk("D c0 tag", commit_tag, 0);
    chk("D c0 value", commit_value, 32'hA0);
    wb_valid = 0;
    tick();
    chk("D c1 tag", commit_tag, 1);
    chk("D c1 value", commit_value, 32'hA1);
    tick();
    chk("D c2 tag", commit_tag, 2);
    chk("D c2 rd", commit_rd, 3);
    tick();
    chk("D drained", commit_valid, 0);

    // branch mispredict flushes the younger ready entry
    do_reset();
    iss(TYPE_BRANCH, 0, 32'h100); tick();
    iss(TYPE_REG, 7, 0); tick();
    issue_valid = 0;
    wb(1, 32'h77); tick();
    wb(0, 32'h200); tick();
    wb_valid = 0;
    tick();
    chk("E commit_valid", commit_valid, 1);
    chk("E commit_type", commit_type, TYPE_BRANCH);
    chk("E clear", clear, 1);
    chk("E redirect", redirect_pc, 32'h200);
    chk("E free in clear", free, 0);
    chk("E tag reset", free_tag, 0);
    iss(TYPE_REG, 9, 0);
    wb(1, 32'h99);
    tick();
    chk("E clear drops", clear, 0);
    chk("E no commit", commit_valid, 0);
    chk("E free", free, 1);
    chk("E issue ignored", free_tag, 0);
    idle();
    tick();
    chk("E young gone", commit_valid, 0);
    iss(TYPE_BRANCH, 0, 32'h300); tick();
    issue_valid = 0;
    wb(0, 32'h300); tick();
    wb_valid = 0;
    tick();
    chk("E good branch", commit_valid, 1);
    chk("E good no clear", clear, 0);
    chk("E good value", commit_value, 32'h300);

    // rdy_in low freezes a ready head
    do_reset();
    iss(TYPE_REG, 9, 0); tick();
    issue_valid = 0;
    wb(0, 32'hAA); tick();
    wb_valid = 0;
    rdy_in = 0;
    iss(TYPE_REG, 4, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("F frozen commit", commit_valid, 0);
      chk("F frozen tag", free_tag, 1);
    end
    rdy_in = 1;
    issue_valid = 0;
    tick();
    chk("F commit_valid", commit_valid, 1);
    chk("F commit_value", commit_value, 32'hAA);
    chk("F commit_rd", commit_rd, 9);
    rdy_in = 0;
    #1;
    chk("F gated pulse", commit_valid, 0);
    rdy_in = 1;
    #1;
    tick();
    chk("F pulse done", commit_valid, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
